// File: rtl/uart_rx_deserializer.sv
// Purpose: 8N1 UART receiver that packs N_WORDS bytes (first byte in LSBs) into one wide valid/ready word.
// Latency: line to rx_s is 2 cycles; m_valid/frame_err/overflow register on the edge after the stop-bit sample.
// Backpressure: reception never stalls; a packet completing while m_data is held unconsumed is dropped with an overflow pulse.
// Optional: define UART_RX_TIMEOUT_EN to discard a partial packet after TIMEOUT_PULSES idle bit periods.
module uart_rx_deserializer #(
  parameter int CLOCKS_PER_PULSE = 2604,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 16,
  parameter int TIMEOUT_PULSES   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overflow
);

  localparam int N_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CNT_W   = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W   = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int WC_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(N_WORDS - 1);

  // Reject parameter sets the sampling scheme cannot honour.
  if (CLOCKS_PER_PULSE < 4) begin : g_chk_cpp
    $error("CLOCKS_PER_PULSE must be at least 4");
  end
  if ((W_OUT % BITS_PER_WORD) != 0) begin : g_chk_wout
    $error("W_OUT must be a multiple of BITS_PER_WORD");
  end
  if (TIMEOUT_PULSES < 1) begin : g_chk_to
    $error("TIMEOUT_PULSES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state;
  logic                     rx_meta;
  logic                     rx_s;
  logic [CNT_W-1:0]         clk_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [WC_W-1:0]          word_cnt;
  logic [BITS_PER_WORD-1:0] shift_q;
  logic [W_OUT-1:0]         asm_buf;
  logic [W_OUT-1:0]         next_buf;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_PULSES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_PULSES - 1);
  logic [CNT_W-1:0] to_clk;
  logic [TO_W-1:0]  to_pulses;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Assembly buffer with the just-received byte dropped into its slot.
  always_comb begin
    next_buf = asm_buf;
    next_buf[word_cnt*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
  end

  // Receive FSM, packet assembly, output register and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      shift_q   <= '0;
      asm_buf   <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      to_clk    <= '0;
      to_pulses <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= HALF_M1;
          end
        end
        START: begin
          if (clk_cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              clk_cnt <= FULL_M1;
              bit_cnt <= LAST_BIT;
            end
          end else begin
            clk_cnt <= clk_cnt - 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == '0) begin
            shift_q <= {rx_s, shift_q[BITS_PER_WORD-1:1]};
            clk_cnt <= FULL_M1;
            if (bit_cnt == '0) state <= STOP;
            else               bit_cnt <= bit_cnt - 1'b1;
          end else begin
            clk_cnt <= clk_cnt - 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == '0) begin
            // Leave mid stop bit so an immediately following start edge is caught.
            state <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else begin
              asm_buf <= next_buf;
              if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
                // A consumer draining the old word this cycle makes room for the new one.
                if (!m_valid || m_ready) begin
                  m_data  <= next_buf;
                  m_valid <= 1'b1;
                end else begin
                  overflow <= 1'b1;
                end
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end else begin
            clk_cnt <= clk_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef UART_RX_TIMEOUT_EN
      // Idle bit-period counter; only runs while a partial packet is pending.
      if (state == IDLE && word_cnt != '0) begin
        if (to_clk == FULL_M1) begin
          to_clk <= '0;
          if (to_pulses == TO_LAST) begin
            to_pulses <= '0;
            word_cnt  <= '0;
          end else begin
            to_pulses <= to_pulses + 1'b1;
          end
        end else begin
          to_clk <= to_clk + 1'b1;
        end
      end else begin
        to_clk    <= '0;
        to_pulses <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Purpose: directed bench for uart_rx_deserializer at 16 clocks per bit, 16-bit output.
// Latency: expects m_valid 155 cycles after the line falls for the last byte of a packet.
// Backpressure: exercises held output, overflow drop and late consumption.
module tb_uart_rx_deserializer;

  localparam int CPP = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        frame_err;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int pkt_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int valid_cycles = 0;
  int valid_rise = 0;
  int last_start = 0;
  logic [15:0] last_pkt = '0;
  logic        prev_valid = 1'b0;

  int pk0, fe0, ov0, vc0;

  uart_rx_deserializer #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(8),
    .W_OUT(16),
    .TIMEOUT_PULSES(32)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rx(rx),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor away from the active edge: inputs change on negedge, sample 1 unit later.
  always begin
    @(negedge clk);
    #1;
    if (m_valid && m_ready) begin
      pkt_cnt  = pkt_cnt + 1;
      last_pkt = m_data;
    end
    if (m_valid) valid_cycles = valid_cycles + 1;
    if (m_valid && !prev_valid) valid_rise = cyc;
    prev_valid = m_valid;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (overflow)  ovf_cnt  = ovf_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame followed by a high gap of `gap` cycles.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int gap);
    logic [9:0] frame;
    frame = {stop_bit, d, 1'b0};
    @(negedge clk);
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPP) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic snap();
    pk0 = pkt_cnt;
    fe0 = ferr_cnt;
    ov0 = ovf_cnt;
    vc0 = valid_cycles;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "time limit");
  end

  initial begin
    rstn    = 1'b0;
    rx      = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_data", m_data, 16'h0000);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Basic packet with ready held high.
    snap();
    send_byte(8'hA5, 1'b1, 20);
    send_byte(8'h3C, 1'b1, 20);
    chk("basic_pkts", pkt_cnt - pk0, 1);
    chk("basic_data", last_pkt, 16'h3CA5);
    chk("basic_valid_cycles", valid_cycles - vc0, 1);
    chk("basic_latency", valid_rise - last_start, 155);
    chk("basic_ferr", ferr_cnt - fe0, 0);
    chk("basic_ovf", ovf_cnt - ov0, 0);

    // Backpressure: second packet is dropped while the first is held.
    snap();
    m_ready = 1'b0;
    send_byte(8'h22, 1'b1, 20);
    send_byte(8'h11, 1'b1, 20);
    send_byte(8'h44, 1'b1, 20);
    send_byte(8'h33, 1'b1, 20);
    #1;
    chk("bp_held_data", m_data, 16'h1122);
    chk("bp_held_valid", m_valid, 1);
    chk("bp_ovf", ovf_cnt - ov0, 1);
    chk("bp_no_accept", pkt_cnt - pk0, 0);
    @(negedge clk);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("bp_accept_data", last_pkt, 16'h1122);
    chk("bp_accept_cnt", pkt_cnt - pk0, 1);
    chk("bp_valid_drop", m_valid, 0);

    // Framing error: bad byte is discarded without advancing the slot.
    snap();
    send_byte(8'h55, 1'b0, 20);
    send_byte(8'h66, 1'b1, 20);
    send_byte(8'h77, 1'b1, 20);
    chk("ferr_cnt", ferr_cnt - fe0, 1);
    chk("ferr_pkts", pkt_cnt - pk0, 1);
    chk("ferr_data", last_pkt, 16'h7766);

    // False start: a short low glitch never reaches DATA.
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    send_byte(8'h01, 1'b1, 20);
    send_byte(8'h02, 1'b1, 20);
    chk("glitch_pkts", pkt_cnt - pk0, 1);
    chk("glitch_data", last_pkt, 16'h0201);
    chk("glitch_ferr", ferr_cnt - fe0, 0);

    // Reset in the middle of a data phase.
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    rx = 1'b1;
    repeat (CPP + 5) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rst_m_data", m_data, 16'h0000);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_overflow", overflow, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'hAA, 1'b1, 20);
    send_byte(8'hBB, 1'b1, 20);
    chk("mid_rst_pkts", pkt_cnt - pk0, 1);
    chk("mid_rst_data", last_pkt, 16'hBBAA);

    // Long idle between the first and second byte of a packet.
    snap();
    send_byte(8'h12, 1'b1, 40 * CPP);
    send_byte(8'h34, 1'b1, 20);
    send_byte(8'h56, 1'b1, 20);
    chk("timeout_pkts", pkt_cnt - pk0, 1);
`ifdef UART_RX_TIMEOUT_EN
    chk("timeout_data", last_pkt, 16'h5634);
`else
    chk("timeout_data", last_pkt, 16'h3412);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side front end of the UART MVM system. It samples the serial `rx` line (8N1, LSB first) and packs `N_WORDS` consecutive bytes into one wide word, first byte in the LSBs. It presents that word on a valid/ready output to the MVM core as the packed `{k, x}` operand bus, with `x` in the low bits.

## Interface
- `CLOCKS_PER_PULSE`, 2604: clock cycles per UART bit (50 MHz / 19200); must be ≥ 4.
- `BITS_PER_WORD`, 8: data bits per UART frame.
- `W_OUT`, 16: output bus width. It must be a multiple of `BITS_PER_WORD`; `N_WORDS = W_OUT/BITS_PER_WORD`.
- `TIMEOUT_PULSES`, 32: idle bit periods before a partial packet is discarded (only with `UART_RX_TIMEOUT_EN`).
- `clk` input 1: single clock; all logic on the rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `rx` input 1: asynchronous serial line, idle high.
- `m_data` output `W_OUT`: assembled packet.
- `m_valid` output 1: `m_data` holds an unconsumed packet.
- `m_ready` input 1: consumer accepts the packet on a cycle where `m_valid && m_ready`.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `overflow` output 1: one-cycle pulse when a completed packet is dropped because the output register is full.

## Operation
- **Input sync:** `rx` passes through a 2-FF synchronizer (reset to 1); all logic uses the synchronized `rx_s`.
- **FSM states:**
  - IDLE: wait for `rx_s == 0`. On detection, load the bit counter and go to START.
  - START: after `CLOCKS_PER_PULSE/2` cycles, sample `rx_s`. If 1 (glitch), return to IDLE. If 0, go to DATA.
  - DATA: sample every `CLOCKS_PER_PULSE` cycles and shift right into the byte register (LSB first). After `BITS_PER_WORD` samples, go to STOP.
  - STOP: after `CLOCKS_PER_PULSE` cycles, sample `rx_s`.
    - If 0: pulse `frame_err`, discard the byte, leave the word counter unchanged, go to IDLE.
    - If 1: write the byte into slot `word_cnt` of the assembly buffer, go to IDLE immediately (mid stop bit), so back-to-back frames are captured.
- **Word counter:** counts 0..`N_WORDS-1` and wraps to 0 when a packet completes.
- **Packet completion:** happens when the last slot is written.
  - If `!m_valid`, or `m_valid && m_ready` on that same cycle: copy the buffer (including the new byte) into `m_data` and set `m_valid`.
  - Otherwise: drop the packet, pulse `overflow`, leave `m_data`/`m_valid` untouched.
- **Output handshake:** `m_valid` clears on `m_valid && m_ready` unless a new packet loads on the same cycle, in which case it stays 1 with the new data. `m_data` is stable while `m_valid && !m_ready`.
- **Assembly buffer:** independent of the output register, so reception never stalls; the next packet assembles while the current one waits.
- **Reset mid-operation:** `rstn` low at any point returns the FSM to IDLE, clears `word_cnt`, the buffers and all outputs. A frame in flight is lost. A low `rx` at release is treated as a start edge.

## Timing
- **Reset values:** `m_data = 0`, `m_valid = 0`, `frame_err = 0`, `overflow = 0`, FSM IDLE, `word_cnt = 0`.
- **Sample points:** let cycle 0 be the first IDLE cycle seeing `rx_s == 0`.
  - Start sample at cycle `CLOCKS_PER_PULSE/2`.
  - Data bit i sampled at `CLOCKS_PER_PULSE/2 + (i+1)*CLOCKS_PER_PULSE`.
  - Stop bit sampled at `CLOCKS_PER_PULSE/2 + (BITS_PER_WORD+1)*CLOCKS_PER_PULSE`.
- **Latency:** `m_valid`, `frame_err` and `overflow` are registered and assert on the edge after the stop-bit sample. Line-to-`rx_s` delay is 2 cycles.
- **Throughput:** one byte per 10 bit periods sustained; tolerates ±3% baud mismatch.

## Configuration
- **`UART_RX_TIMEOUT_EN` defined:** an idle counter counts bit periods spent in IDLE while `word_cnt != 0`. Reaching `TIMEOUT_PULSES` resets `word_cnt` to 0 and discards the partial packet; there is no output pulse. A start edge clears the counter.
- **Not defined:** no timeout logic. A partial packet waits indefinitely, and `TIMEOUT_PULSES` is unused.

## Test plan
Benches use `CLOCKS_PER_PULSE = 16` and `W_OUT = 16`.
- **Basic packet:** send 0xA5 then 0x3C with `m_ready = 1`. `m_valid` pulses for 1 cycle, 1 cycle after the second stop sample, with `m_data = 16'h3CA5`. No `frame_err`/`overflow`.
- **Backpressure/overflow:** `m_ready = 0`; send packet 0x1122 then packet 0x3344. `m_data` stays 0x1122, `overflow` pulses once after the fourth byte. Raising `m_ready` consumes 0x1122 and `m_valid` drops.
- **Framing error:** send 0x55 with stop bit = 0, then 0x66, 0x77. `frame_err` pulses once, and the next packet is `16'h7766`.
- **False start:** a 4-cycle low glitch on `rx`, then a clean 0x01, 0x02. No byte is captured from the glitch; output is `16'h0201`.
- **Reset mid-frame:** assert `rstn` low during DATA of byte 1, release, then send 0xAA, 0xBB. All outputs read 0 during reset; output is `16'hBBAA`.
- **Timeout (`UART_RX_TIMEOUT_EN`):** send 0x12, idle 40 bit periods, send 0x34, 0x56. Output is `16'h5634`. Without the macro, output is `16'h3412`.
